// File: rtl/c880_misr_compactor_if.sv
// Response stream from the c880 netlist into the signature compactor.
// Uses a valid/ready handshake, and a beat transfers on a rising edge with valid & ready.
interface c880_misr_compactor_if #(
   parameter int RESP_W = 26
);
   logic              resp_valid;
   logic [RESP_W-1:0] resp_data;
   logic              resp_ready;

   modport master (output resp_valid, output resp_data, input resp_ready);
   modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/c880_misr_compactor.sv
// Folds c880 response vectors into a 32-bit MISR over a programmed pattern count,
// then compares the final signature against a golden value.
module c880_misr_compactor #(
   parameter int              RESP_W = 26,
   parameter int              SIG_W  = 32,
   parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
   parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
   parameter int              CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [CNT_W-1:0]     num_patterns_i,
   input  logic [SIG_W-1:0]     golden_i,
   input  logic                 abort_i,
   c880_misr_compactor_if.slave resp_if,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [SIG_W-1:0]     signature_o,
   output logic [CNT_W-1:0]     count_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SIG_W-1:0]   sig_q, sig_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   num_q, num_d;
   logic [SIG_W-1:0]   gold_q, gold_d;
   logic               pass_q, pass_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               accept_s;

   // Shift left, apply feedback when the MSB falls out, and inject the zero-extended response.
   function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                  input logic [RESP_W-1:0] data);
      logic [SIG_W-1:0] ext;
      logic [SIG_W-1:0] fb;
      ext              = '0;
      ext[RESP_W-1:0]  = data;
      fb               = sig[SIG_W-1] ? POLY : '0;
      return {sig[SIG_W-2:0], 1'b0} ^ fb ^ ext;
   endfunction

   assign accept_s = resp_if.resp_valid & ready_q;

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      gold_d  = gold_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Abort takes priority over start, and it only has a visible effect in DONE.
            if (abort_i) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
            end else if (start_i) begin
               sig_d  = SEED;
               cnt_d  = '0;
               num_d  = num_patterns_i;
               gold_d = golden_i;
               if (num_patterns_i == '0) begin
                  state_d = ST_DONE;
                  pass_d  = (SEED == golden_i);
               end else begin
                  state_d = ST_RUN;
                  pass_d  = 1'b0;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (accept_s) begin
               sig_d = misr_next(sig_q, resp_if.resp_data);
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_d == num_q) begin
                  state_d = ST_DONE;
                  pass_d  = (sig_d == gold_q);
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_RUN);
      busy_d  = (state_d == ST_RUN);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         num_q   <= '0;
         gold_q  <= '0;
         pass_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         gold_q  <= gold_d;
         pass_q  <= pass_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign resp_if.resp_ready = ready_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign pass_o             = pass_q;
   assign signature_o        = sig_q;
   assign count_o            = cnt_q;

endmodule

// File: tb/tb_c880_misr_compactor.sv
// Three compactors with different seeds share one stimulus stream; a reference model
// predicts each run's result into a queue that a done-edge monitor drains.
module tb_c880_misr_compactor;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEEDS [3] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF};

   typedef struct packed {
      logic [2:0][31:0] sig;
      logic [15:0]      cnt;
      logic [2:0]       pass;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_r = 1'b0;
   logic        abort_r = 1'b0;
   logic        valid_r = 1'b0;
   logic [25:0] data_r  = '0;
   logic [15:0] num_r   = '0;
   logic [31:0] gold_r  = '0;

   logic [2:0]        ready_w, busy_w, done_w, pass_w;
   logic [2:0][31:0]  sig_w;
   logic [2:0][15:0]  cnt_w;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      c880_misr_compactor_if #(.RESP_W(26)) rif ();
      assign rif.resp_valid = valid_r;
      assign rif.resp_data  = data_r;
      assign ready_w[k]     = rif.resp_ready;
      c880_misr_compactor #(.SEED(SEEDS[k])) dut (
         .clk            (clk),
         .rst            (rst),
         .start_i        (start_r),
         .num_patterns_i (num_r),
         .golden_i       (gold_r),
         .abort_i        (abort_r),
         .resp_if        (rif.slave),
         .busy_o         (busy_w[k]),
         .done_o         (done_w[k]),
         .pass_o         (pass_w[k]),
         .signature_o    (sig_w[k]),
         .count_o        (cnt_w[k])
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_sig [3];
   logic [15:0] m_cnt, m_num;
   logic [31:0] m_gold;
   int          m_state;   // 0 idle, 1 run, 2 done
   exp_t        q [$];
   logic        done_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Signature polynomial arithmetic: multiply by x modulo the polynomial, then add the vector.
   function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [25:0] d);
      logic [31:0] r;
      r = s << 1;
      if (s[31]) r = r ^ POLY;
      return r ^ {6'b0, d};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m_sig[k] = SEEDS[k];
      m_cnt = '0; m_num = '0; m_gold = '0; m_state = 0;
   endtask

   task automatic model_push();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         e.sig[k]  = m_sig[k];
         e.pass[k] = (m_sig[k] == m_gold);
      end
      e.cnt = m_cnt;
      q.push_back(e);
   endtask

   task automatic model_edge();
      if (m_state == 1) begin
         if (abort_r) m_state = 0;
         else if (valid_r) begin
            for (int k = 0; k < 3; k++) m_sig[k] = ref_misr(m_sig[k], data_r);
            m_cnt = m_cnt + 16'd1;
            if (m_cnt == m_num) begin
               m_state = 2;
               model_push();
            end
         end
      end else begin
         if (abort_r) m_state = 0;
         else if (start_r) begin
            for (int k = 0; k < 3; k++) m_sig[k] = SEEDS[k];
            m_cnt = '0; m_num = num_r; m_gold = gold_r;
            if (num_r == 16'd0) begin
               m_state = 2;
               model_push();
            end else m_state = 1;
         end
      end
   endtask

   task automatic check_cycle();
      for (int k = 0; k < 3; k++) begin
         check("resp_ready", 32'(ready_w[k]), 32'(m_state == 1));
         check("busy", 32'(busy_w[k]), 32'(m_state == 1));
         check("done", 32'(done_w[k]), 32'(m_state == 2));
         check("count", 32'(cnt_w[k]), 32'(m_cnt));
         check("signature", sig_w[k], m_sig[k]);
      end
   endtask

   task automatic step(input logic v, input logic [25:0] d, input logic st, input logic ab,
                       input logic [15:0] n, input logic [31:0] g);
      valid_r = v; data_r = d; start_r = st; abort_r = ab; num_r = n; gold_r = g;
      @(posedge clk);
      model_edge();
      #1;
      valid_r = 1'b0; start_r = 1'b0; abort_r = 1'b0;
      check_cycle();
   endtask

   task automatic check_reset(input string tag);
      for (int k = 0; k < 3; k++) begin
         check({tag, "_ready"}, 32'(ready_w[k]), 32'd0);
         check({tag, "_busy"},  32'(busy_w[k]),  32'd0);
         check({tag, "_done"},  32'(done_w[k]),  32'd0);
         check({tag, "_pass"},  32'(pass_w[k]),  32'd0);
         check({tag, "_sig"},   sig_w[k],        SEEDS[k]);
         check({tag, "_count"}, 32'(cnt_w[k]),   32'd0);
      end
   endtask

   // Monitor: each rising edge of done consumes one predicted result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) done_prev = 1'b0;
         else begin
            if (done_w[2] && !done_prev) begin
               check("done_all", 32'(done_w), 32'd7);
               if (q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_done: got done=1 expected no pending result");
               end else begin
                  e = q.pop_front();
                  for (int k = 0; k < 3; k++) begin
                     check("sb_signature", sig_w[k], e.sig[k]);
                     check("sb_pass", 32'(pass_w[k]), 32'(e.pass[k]));
                     check("sb_count", 32'(cnt_w[k]), 32'(e.cnt));
                  end
               end
            end
            done_prev = done_w[2];
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] s2;
      logic [25:0] dat [16];
      logic [31:0] g, fs;
      int          n, ptr, budget;
      logic        v, ab, st, acc;

      model_reset();
      #12;
      check_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single beat, seed 0
      step(1'b0, 26'h0, 1'b1, 1'b0, 16'd1, 32'h1);
      step(1'b1, 26'h1, 1'b0, 1'b0, 16'd0, 32'h0);
      check("tp1_sig", sig_w[0], 32'h00000001);
      check("tp1_pass", 32'(pass_w[0]), 32'd1);
      check("tp1_done", 32'(done_w[0]), 32'd1);

      // Restart straight from DONE, two beats, golden mismatch
      step(1'b0, 26'h0, 1'b1, 1'b0, 16'd2, 32'h3);
      check("tp2_done_drop", 32'(done_w[0]), 32'd0);
      step(1'b1, 26'h1, 1'b0, 1'b0, 16'd0, 32'h0);
      step(1'b1, 26'h0, 1'b0, 1'b0, 16'd0, 32'h0);
      check("tp2_sig", sig_w[0], 32'h00000002);
      check("tp2_pass", 32'(pass_w[0]), 32'd0);
      check("tp2_done", 32'(done_w[0]), 32'd1);

      // Feedback path from seed 0x80000000
      step(1'b0, 26'h0, 1'b0, 1'b1, 16'd0, 32'h0);
      step(1'b0, 26'h0, 1'b1, 1'b0, 16'd1, 32'h04C11DB7);
      step(1'b1, 26'h0, 1'b0, 1'b0, 16'd0, 32'h0);
      check("tp3_sig", sig_w[1], 32'h04C11DB7);
      check("tp3_pass", 32'(pass_w[1]), 32'd1);

      // Zero-length run goes straight to DONE
      step(1'b0, 26'h0, 1'b0, 1'b1, 16'd0, 32'h0);
      step(1'b1, 26'h5, 1'b1, 1'b0, 16'd0, 32'hFFFFFFFF);
      check("tp4_done", 32'(done_w[2]), 32'd1);
      check("tp4_pass", 32'(pass_w[2]), 32'd1);
      step(1'b1, 26'h5, 1'b0, 1'b0, 16'd0, 32'h0);
      step(1'b0, 26'h0, 1'b0, 1'b1, 16'd0, 32'h0);

      // Abort with a simultaneous beat after two beats, then re-seed
      step(1'b0, 26'h0, 1'b1, 1'b0, 16'd4, 32'h0);
      step(1'b1, 26'h2AAAAAA, 1'b0, 1'b0, 16'd0, 32'h0);
      step(1'b1, 26'h1555555, 1'b0, 1'b0, 16'd0, 32'h0);
      s2 = m_sig[2];
      step(1'b1, 26'h3FFFFFF, 1'b0, 1'b1, 16'd0, 32'h0);
      check("tp5_count", 32'(cnt_w[2]), 32'd2);
      check("tp5_sig", sig_w[2], s2);
      check("tp5_done", 32'(done_w[2]), 32'd0);
      step(1'b0, 26'h0, 1'b1, 1'b0, 16'd3, 32'h0);
      check("tp5_reseed", sig_w[2], 32'hFFFFFFFF);

      // Gapped valid, mid-run start ignored
      step(1'b1, 26'h0000011, 1'b0, 1'b0, 16'd0, 32'h0);
      step(1'b0, 26'h0, 1'b1, 1'b0, 16'd9, 32'h0);
      step(1'b1, 26'h0000022, 1'b0, 1'b0, 16'd0, 32'h0);
      step(1'b0, 26'h0, 1'b0, 1'b0, 16'd0, 32'h0);
      step(1'b1, 26'h0000033, 1'b0, 1'b0, 16'd0, 32'h0);
      check("tp6_count", 32'(cnt_w[2]), 32'd3);
      check("tp6_done", 32'(done_w[2]), 32'd1);

      // Reset mid-run acts asynchronously
      step(1'b0, 26'h0, 1'b1, 1'b0, 16'd5, 32'h0);
      step(1'b1, 26'h0ABCDEF, 1'b0, 1'b0, 16'd0, 32'h0);
      #3 rst = 1'b1;
      #1 check_reset("midrun_reset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 26'h0, 1'b0, 1'b0, 16'd0, 32'h0);

      // Randomized runs
      for (int r = 0; r < 40; r++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < 16; i++) dat[i] = 26'($urandom);
         fs = SEEDS[2];
         for (int i = 0; i < n; i++) fs = ref_misr(fs, dat[i]);
         g = ($urandom_range(0, 1) == 1) ? fs : $urandom;
         step(1'b0, 26'h0, 1'b1, 1'b0, 16'(n), g);
         ptr = 0;
         budget = 200;
         while (m_state == 1 && budget > 0) begin
            v   = ($urandom_range(0, 3) != 0);
            ab  = ($urandom_range(0, 24) == 0);
            st  = ($urandom_range(0, 9) == 0);
            acc = v && !ab;
            step(v, dat[ptr], st, ab, 16'($urandom_range(0, 3)), $urandom);
            if (acc && ptr < 15) ptr++;
            budget--;
         end
         if (m_state == 1) begin
            n_tests++; n_fail++;
            $display("FAIL run_timeout: got still running expected done");
         end
         if ($urandom_range(0, 2) == 0) step(1'b0, 26'h0, 1'b0, 1'b1, 16'd0, 32'h0);
      end

      repeat (3) step(1'b0, 26'h0, 1'b0, 1'b0, 16'd0, 32'h0);
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/c880_misr_compactor.md
Name: c880_misr_compactor

Overview:
- Response compactor sitting directly downstream of the c880 benchmark netlist in the test/fault-injection flow.
- Accepts the 26 c880 primary-output bits (outputs 388..880, concatenated in declaration order, 388 = MSB) as one response vector per cycle via valid/ready.
- Folds each accepted vector into a 32-bit multiple-input signature register (MISR) over a programmed pattern count.
- Compares the final signature against a golden value and reports pass/fail.

Parameters:
- RESP_W, 26, response vector width (c880 output count)
- SIG_W, 32, signature width; must be >= RESP_W
- POLY, 32'h04C11DB7, MISR feedback polynomial (x^SIG_W term implicit)
- SEED, 32'hFFFFFFFF, signature value loaded at start
- CNT_W, 16, pattern counter width

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; begins a compaction run
- num_patterns  input  CNT_W  response vectors to compact; sampled on start
- golden  input  SIG_W  expected signature; sampled on start
- abort  input  1  cancels a run in progress
- resp_valid  input  1  response vector present
- resp_data  input  RESP_W  c880 output vector
- resp_ready  output  1  compactor accepts a vector this cycle
- busy  output  1  run in progress
- done  output  1  run complete; result valid
- pass  output  1  final signature == golden; meaningful only while done=1
- signature  output  SIG_W  current MISR contents
- count  output  CNT_W  vectors accepted in the current run

Behaviour:
- Reset (async assert, sync release): state=IDLE, signature=SEED, count=0, latched num/golden=0; resp_ready=0, busy=0, done=0, pass=0.
- Registered outputs. A beat is accepted when resp_valid & resp_ready at a rising edge.
- MISR update per accepted beat: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_data). count increments by 1.
- FSM states:
  - IDLE: resp_ready=0.
    - start with num_patterns != 0: load SEED, count=0, latch num/golden; go to RUN next cycle.
    - start with num_patterns == 0: load SEED, count=0, latch golden; go directly to DONE, with pass = (SEED == golden).
  - RUN: busy=1; resp_ready=1 in every RUN cycle (no backpressure), so compaction latency is 1 cycle per beat.
    - Accepting the beat that makes count == latched num: next state is DONE. done and pass assert on the same edge that writes the final signature.
    - start in RUN is ignored.
    - abort in RUN (with or without a simultaneous beat): go to IDLE. The beat is discarded, signature and count hold their pre-abort values, done=0.
  - DONE: done=1, busy=0, resp_ready=0. Signature, count and pass are held.
    - start restarts exactly as from IDLE; done drops the same edge.
    - abort returns to IDLE (done=0, signature held).
- abort in IDLE has no effect. abort and start in the same cycle: abort wins.
- No counter wrap: a run terminates at count == num ≤ 2^CNT_W-1.
- rst asserted mid-run: immediate return to reset values; no partial result is reported.

Test Plan:
- Override SEED=0. start, num=1, golden=0x00000001; one beat resp_data=26'h1 → signature=0x00000001, count=1, done=1 and pass=1 the edge after the beat.
- Override SEED=0. num=2; beats 26'h1 then 26'h0 → signature=0x00000002; with golden=0x3 → pass=0, done=1.
- Override SEED=0x80000000. num=1; beat 26'h0 → signature=0x04C11DB7, which exercises the feedback path.
- Default params. start with num=0 and golden=0xFFFFFFFF → done=1 and pass=1 on the next edge; resp_ready never asserts.
- num=4; after 2 beats assert abort together with a valid beat → state IDLE, count=2, signature equals its 2-beat value, done=0. A following start re-seeds to 0xFFFFFFFF.
- num=3 with resp_valid toggling 1,0,1,0,1 → exactly 3 accepts, count=3, done=1. A start pulse in mid-run is ignored. rst pulsed mid-run → all outputs return to reset values asynchronously.
